// File: rtl/out_uart_pkg.sv
// out_uart_pkg: shared definitions for the OUT-register UART logger.
//   - uart_state_e : framing FSM state encoding (also exported for debug)
//   - IDLE_LEVEL / START_LEVEL : serial line levels
//   - clog2() : pointer width helper for the FIFO
package out_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_uart_tx_if.sv
// out_uart_tx_if: bundle between the CPU OUT-register path and the UART logger.
//   write    : push strobe (CPU OUT-register write enable)
//   data     : 16-bit value being written into OUT
//   tx       : UART serial line, idle high
//   busy     : FIFO non-empty or frame in progress
//   full     : FIFO holds FIFO_DEPTH entries
//   overflow : sticky, a push was dropped
//   state    : framing FSM state, for observation only
// Handshake: write is a one-cycle push request with no ready; a push at a
// rising edge is taken when full is low at that edge, otherwise the word is
// dropped and overflow latches high until reset.
interface out_uart_tx_if;
  import out_uart_pkg::*;

  logic        write;
  logic [15:0] data;
  logic        tx;
  logic        busy;
  logic        full;
  logic        overflow;
  uart_state_e state;

  modport master (
    output write, data,
    input  tx, busy, full, overflow, state
  );

  modport slave (
    input  write, data,
    output tx, busy, full, overflow, state
  );

endinterface

// File: rtl/out_fifo.sv
// out_fifo: synchronous FIFO with drop-on-full.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write request and data; ignored (drop pulse) when full
//   pop/dout : read request and head-of-queue data (dout valid when !empty)
//   full     : count == DEPTH
//   empty    : count == 0
//   drop     : one-cycle pulse when a push is refused because full
// A push while full is refused even if a pop happens the same cycle.
module out_fifo
  import out_uart_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign drop    = push & full;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/out_uart_tx.sv
// out_uart_tx: logs CPU OUT-register writes on a UART line.
// Each 16-bit write is queued in out_fifo and sent as two 8N1 frames,
// high byte first, LSB first within a byte, CLK_DIV clocks per bit.
//   clk : system clock
//   rst : synchronous active-high reset (aborts any frame in progress)
//   bus : out_uart_tx_if.slave (write/data in; tx/busy/full/overflow/state out)
// Optional macro OUT_UART_PARITY_EN inserts an even-parity bit between the
// data bits and the stop bit.
module out_uart_tx
  import out_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  out_uart_tx_if.slave bus
);

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        byte_hi_q, byte_hi_d;
  logic [15:0] word_q, word_d;
  logic        tx_q, tx_d;
  logic        overflow_q;

  logic        tick;
  logic        pop;
  logic        fifo_empty, fifo_full, fifo_drop;
  logic [15:0] fifo_dout;
  logic [7:0]  cur_byte;

  out_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.write),
    .pop   (pop),
    .din   (bus.data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign tick     = (cnt_q == DIV_M1);
  assign cur_byte = byte_hi_q ? word_q[15:8] : word_q[7:0];

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_hi_q  <= 1'b1;
      word_q     <= '0;
      tx_q       <= IDLE_LEVEL;
      overflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      byte_hi_q <= byte_hi_d;
      word_q    <= word_d;
      tx_q      <= tx_d;
      if (fifo_drop) overflow_q <= 1'b1;
    end
  end

  // Next-state logic. The baud counter runs in every non-idle state and
  // wraps on tick, so each state lasts exactly CLK_DIV cycles per bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    byte_hi_d = byte_hi_q;
    word_d    = word_q;
    pop       = 1'b0;
    if (state_q != ST_IDLE) cnt_d = tick ? '0 : cnt_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          word_d    = fifo_dout;
          byte_hi_d = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef OUT_UART_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) begin
          // High byte done: go straight into the low byte's start bit.
          if (byte_hi_q) begin
            byte_hi_d = 1'b0;
            state_d   = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode. The line level is registered, so tx follows the state
  // by one cycle and never depends combinationally on write/data.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_q)
      ST_START:  tx_d = START_LEVEL;
      ST_DATA:   tx_d = cur_byte[bit_idx_q];
`ifdef OUT_UART_PARITY_EN
      ST_PARITY: tx_d = ^cur_byte;
`endif
      default:   tx_d = IDLE_LEVEL;
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.overflow = overflow_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx: self-checking bench for out_uart_tx (CLK_DIV=4, depth 4).
// A serial receiver decodes tx into words; a waveform model built from the
// framing rules checks exact cycle timing of one word.
module tb_out_uart_tx;
  import out_uart_pkg::*;

  localparam int CLK_DIV = 4;

  logic clk;
  logic rst;
  out_uart_tx_if bus();

  out_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  bit          wave_q[$];
  bit          mon_en = 1'b1;
  bit          mon_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference line waveform for one word, from the framing rules.
  function automatic void push_bit(input bit v);
    for (int c = 0; c < CLK_DIV; c++) wave_q.push_back(v);
  endfunction

  function automatic void build_wave(input logic [15:0] w);
    logic [7:0] b;
    wave_q.delete();
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? w[15:8] : w[7:0];
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(b[i]);
`ifdef OUT_UART_PARITY_EN
      push_bit(^b);
`endif
      push_bit(1'b1);
    end
  endfunction

  // ---------------- serial receiver ----------------
  initial begin
    logic [7:0] b;
    logic [7:0] hi_b;
    bit         hi_done;
    hi_done = 1'b0;
    b       = '0;
    hi_b    = '0;
    forever begin
      @(negedge clk);
      if (mon_en && bus.tx == 1'b0) begin
        mon_busy = 1'b1;
        repeat (CLK_DIV/2) @(negedge clk);
        check("rx_start_mid", 32'(bus.tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = bus.tx;
        end
`ifdef OUT_UART_PARITY_EN
        repeat (CLK_DIV) @(negedge clk);
        check("rx_parity", 32'(bus.tx), 32'(^b));
`endif
        repeat (CLK_DIV) @(negedge clk);
        check("rx_stop", 32'(bus.tx), 32'd1);
        if (!hi_done) begin
          hi_b    = b;
          hi_done = 1'b1;
        end else begin
          got_q.push_back({hi_b, b});
          hi_done = 1'b0;
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; the push is sampled at the following posedge.
  task automatic drive_write(input logic [15:0] w);
    bus.write = 1'b1;
    bus.data  = w;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.busy || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", 32'(bus.busy), 32'd0);
    repeat (4*CLK_DIV) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] w;
    bus.write = 1'b0;
    bus.data  = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word, exact waveform and latency.
    build_wave(16'h1234);
    exp_q.push_back(16'h1234);
    drive_write(16'h1234);
    check("lat_edge_n", 32'(bus.tx), 32'd1);
    @(negedge clk);
    check("lat_edge_n1", 32'(bus.tx), 32'd1);
    check("busy_after_pop", 32'(bus.busy), 32'd1);
    for (int i = 0; i < wave_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("wave[%0d]", i), 32'(bus.tx), 32'(wave_q[i]));
    end
    @(negedge clk);
    check("wave_end_tx", 32'(bus.tx), 32'd1);
    check("wave_end_busy", 32'(bus.busy), 32'd0);
    wait_idle(2000);

    // Five back-to-back pushes fit (first pops at once); sixth is dropped.
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(16'(i));
      drive_write(16'(i));
    end
    check("b2b_full", 32'(bus.full), 32'd1);
    check("b2b_ovf_before", 32'(bus.overflow), 32'd0);
    drive_write(16'h0006);
    check("b2b_ovf_after", 32'(bus.overflow), 32'd1);
    check("b2b_full_after", 32'(bus.full), 32'd1);
    wait_idle(4000);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Push coincident with the pop edge: occupancy stays at one.
    exp_q.push_back(16'h0A0A);
    drive_write(16'h0A0A);
    exp_q.push_back(16'h0B0B);
    drive_write(16'h0B0B);
    check("pp_full1", 32'(bus.full), 32'd0);
    check("pp_busy", 32'(bus.busy), 32'd1);
    exp_q.push_back(16'h0C0C);
    drive_write(16'h0C0C);
    exp_q.push_back(16'h0D0D);
    drive_write(16'h0D0D);
    check("pp_full3", 32'(bus.full), 32'd0);
    exp_q.push_back(16'h0E0E);
    drive_write(16'h0E0E);
    check("pp_full4", 32'(bus.full), 32'd1);
    wait_idle(4000);

    // Reset in the middle of a data byte aborts the frame.
    mon_en = 1'b0;
    drive_write(16'hA5A5);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(bus.tx), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_full", 32'(bus.full), 32'd0);
    check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    repeat (3*CLK_DIV) @(negedge clk);
    check("no_resume_tx", 32'(bus.tx), 32'd1);
    check("no_resume_busy", 32'(bus.busy), 32'd0);
    mon_en = 1'b1;
    exp_q.push_back(16'h00FF);
    drive_write(16'h00FF);
    wait_idle(2000);

    // Random words with random spacing, pushed only while not full.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      if (!bus.full) begin
        w = 16'($urandom_range(0, 65535));
        exp_q.push_back(w);
        drive_write(w);
      end
    end
    wait_idle(8000);
    check("final_overflow", 32'(bus.overflow), 32'd0);

    // Scoreboard.
    check("rx_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rx_word[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
